// File: rtl/input_shift_register_if.sv
// Input shift register bus bundle.
// Groups the FSM-decode requests, GPIO/MOV data, RX FIFO status and the
// ISR results into one bundle.
//   master : instruction decode / FIFO side. Drives the requests and the data.
//   slave  : the ISR. Drives mov_out, data_out, fifo_push, stall and
//            input_shift_counter.
interface input_shift_register_if;
  logic [31:0] in_data;
  logic        shift_en;
  logic [4:0]  shift_count;
  logic        shiftdir;
  logic        autopush;
  logic [4:0]  push_thresh;
  logic        push_req;
  logic        push_block;
  logic        mov_en;
  logic [31:0] mov_in;
  logic        fifo_full;
  logic [31:0] mov_out;
  logic [31:0] data_out;
  logic        fifo_push;
  logic        stall;
  logic [5:0]  input_shift_counter;

  modport master (
    output in_data, shift_en, shift_count, shiftdir, autopush, push_thresh,
           push_req, push_block, mov_en, mov_in, fifo_full,
    input  mov_out, data_out, fifo_push, stall, input_shift_counter
  );

  modport slave (
    input  in_data, shift_en, shift_count, shiftdir, autopush, push_thresh,
           push_req, push_block, mov_en, mov_in, fifo_full,
    output mov_out, data_out, fifo_push, stall, input_shift_counter
  );
endinterface

// File: rtl/input_shift_register.sv
// Per-state-machine input shift register (ISR).
// Shifts 1-32 bits per cycle from the GPIO input bus into a 32-bit register
// and counts the bits shifted. Completed words go to the RX FIFO in two ways:
// by autopush once a threshold is reached, or by an explicit PUSH.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - slave side of input_shift_register_if. It carries the requests,
//         the data, the FIFO status and the push/stall results.
// fifo_push, data_out and stall are combinational, so the RX FIFO captures
// data_out on the same edge that updates the ISR.
module input_shift_register (
  input  logic                         clk,
  input  logic                         rst,
  input_shift_register_if.slave        bus
);

  logic [31:0] isr, isr_d, isr_next, din_mask;
  logic [5:0]  cnt, cnt_d, cnt_next, n, thresh;
  logic [6:0]  cnt_sum;
  logic        push_o, stall_o;
  logic [31:0] data_o;

  // An encoded count of 0 stands for a full 32-bit word.
  assign n      = (bus.shift_count == 5'd0) ? 6'd32 : {1'b0, bus.shift_count};
  assign thresh = (bus.push_thresh == 5'd0) ? 6'd32 : {1'b0, bus.push_thresh};

  // Shifted-in data and the count that would result from a shift.
  always_comb begin
    din_mask = (n == 6'd32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    isr_next = bus.in_data;
    if (n != 6'd32) begin
      if (bus.shiftdir)
        isr_next = (isr >> n) | ((bus.in_data & din_mask) << (6'd32 - n));
      else
        isr_next = (isr << n) | (bus.in_data & din_mask);
    end
    cnt_sum  = {1'b0, cnt} + {1'b0, n};
    cnt_next = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
  end

  // Request arbitration. MOV wins over PUSH, and PUSH wins over IN.
  // A losing request is dropped.
  always_comb begin
    isr_d   = isr;
    cnt_d   = cnt;
    push_o  = 1'b0;
    stall_o = 1'b0;
    data_o  = 32'h0;
    if (bus.mov_en) begin
      isr_d = bus.mov_in;
      cnt_d = 6'd0;
    end else if (bus.push_req) begin
      if (!bus.fifo_full) begin
        push_o = 1'b1;
        data_o = isr;
        isr_d  = 32'h0;
        cnt_d  = 6'd0;
      end else if (bus.push_block) begin
        stall_o = 1'b1;
      end else begin
        // Non-blocking push into a full FIFO drops the word.
        isr_d = 32'h0;
        cnt_d = 6'd0;
      end
    end else if (bus.shift_en) begin
      if (bus.autopush && (cnt_next >= thresh)) begin
        if (!bus.fifo_full) begin
          push_o = 1'b1;
          data_o = isr_next;
          isr_d  = 32'h0;
          cnt_d  = 6'd0;
        end else begin
          // Hold off the shift until the FIFO frees, so no input bits are lost.
          stall_o = 1'b1;
        end
      end else begin
        isr_d = isr_next;
        cnt_d = cnt_next;
      end
    end
    // Reset masks the strobes in the same cycle it is asserted.
    if (rst) begin
      push_o  = 1'b0;
      stall_o = 1'b0;
      data_o  = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isr <= 32'h0;
      cnt <= 6'd0;
    end else begin
      isr <= isr_d;
      cnt <= cnt_d;
    end
  end

  assign bus.mov_out             = isr;
  assign bus.input_shift_counter = cnt;
  assign bus.fifo_push           = push_o;
  assign bus.stall               = stall_o;
  assign bus.data_out            = data_o;

endmodule

// File: tb/tb_input_shift_register.sv
module tb_input_shift_register;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_shift_register_if bus ();
  input_shift_register dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] isr;
    logic [5:0]  cnt;
    logic        stall;
    logic        push;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] push_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit drive_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: the per-cycle expectations and the pushed words are checked
  // independently of the stimulus process.
  initial begin
    exp_t e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("isr",       bus.mov_out, e.isr);
        chk("counter",   {26'h0, bus.input_shift_counter}, {26'h0, e.cnt});
        chk("stall",     {31'h0, bus.stall}, {31'h0, e.stall});
        chk("fifo_push", {31'h0, bus.fifo_push}, {31'h0, e.push});
        if (!e.push) chk("data_out_idle", bus.data_out, 32'h0);
      end
      if (bus.fifo_push === 1'b1) begin
        if (push_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_push: got 0x%08h expected no push", bus.data_out);
        end else begin
          w = push_q.pop_front();
          chk("push_word", bus.data_out, w);
        end
      end
    end
  end

  // Caller sets inputs at posedge+1. Expected values describe this cycle:
  // the state from the previous edge plus the combinational outputs.
  task automatic cyc(input logic [31:0] e_isr, input logic [5:0] e_cnt,
                     input logic e_stall, input logic e_push, input logic [31:0] e_word);
    cyc_q.push_back('{isr: e_isr, cnt: e_cnt, stall: e_stall, push: e_push});
    if (e_push) push_q.push_back(e_word);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.shift_en = 0; bus.push_req = 0; bus.mov_en = 0; bus.fifo_full = 0;
  endtask

  task automatic shift(input logic dir, input logic [4:0] cnt, input logic [31:0] d);
    bus.shift_en = 1; bus.shiftdir = dir; bus.shift_count = cnt; bus.in_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    bus.in_data = 0; bus.shift_count = 0; bus.shiftdir = 0; bus.autopush = 0;
    bus.push_thresh = 0; bus.push_block = 0; bus.mov_in = 0;
    idle();
    @(posedge clk); #1;
    cyc(32'h0, 0, 0, 0, 0);                 // reset held: all outputs 0
    rst = 0;

    // Left shift, n=8, twice
    shift(0, 5'd8, 32'h0000_00A5);
    cyc(32'h0, 0, 0, 0, 0);
    cyc(32'h0000_00A5, 8, 0, 0, 0);
    idle(); bus.mov_en = 1; bus.mov_in = 32'h0;
    cyc(32'h0000_A5A5, 16, 0, 0, 0);        // MOV of 0 clears the ISR for the next test

    // Right shift, n=8, then n=32, then saturation
    idle(); shift(1, 5'd8, 32'h0000_00A5);
    cyc(32'h0, 0, 0, 0, 0);
    shift(1, 5'd0, 32'hDEAD_BEEF);
    cyc(32'hA500_0000, 8, 0, 0, 0);
    shift(1, 5'd8, 32'h0000_0001);
    cyc(32'hDEAD_BEEF, 32, 0, 0, 0);
    idle(); bus.mov_en = 1; bus.mov_in = 32'h0;
    cyc(32'h01DE_ADBE, 32, 0, 0, 0);        // saturated counter, shift still applied

    // Autopush at T=16
    idle(); bus.autopush = 1; bus.push_thresh = 5'd16;
    shift(1, 5'd8, 32'h11);
    cyc(32'h0, 0, 0, 0, 0);
    shift(1, 5'd8, 32'h22);
    cyc(32'h1100_0000, 8, 0, 1, 32'h2211_0000);
    idle();
    cyc(32'h0, 0, 0, 0, 0);

    // Autopush stall while the FIFO is full for 3 cycles
    shift(1, 5'd8, 32'h11);
    cyc(32'h0, 0, 0, 0, 0);
    shift(1, 5'd8, 32'h22); bus.fifo_full = 1;
    for (int i = 0; i < 3; i++) cyc(32'h1100_0000, 8, 1, 0, 0);
    bus.fifo_full = 0;
    cyc(32'h1100_0000, 8, 0, 1, 32'h2211_0000);
    idle();
    cyc(32'h0, 0, 0, 0, 0);

    // Explicit PUSH: blocking stall, then dropped, then a normal push
    bus.autopush = 0; bus.mov_en = 1; bus.mov_in = 32'h1234_5678;
    cyc(32'h0, 0, 0, 0, 0);
    idle(); bus.push_req = 1; bus.fifo_full = 1; bus.push_block = 1;
    cyc(32'h1234_5678, 0, 1, 0, 0);
    bus.push_block = 0;
    cyc(32'h1234_5678, 0, 0, 0, 0);
    idle(); bus.mov_en = 1;
    cyc(32'h0, 0, 0, 0, 0);                 // the dropped push cleared the ISR
    idle(); bus.push_req = 1;
    cyc(32'h1234_5678, 0, 0, 1, 32'h1234_5678);
    idle();
    cyc(32'h0, 0, 0, 0, 0);

    // All three requests at once: MOV wins
    bus.autopush = 1; bus.mov_en = 1; bus.push_req = 1; bus.mov_in = 32'hCAFE_F00D;
    shift(1, 5'd8, 32'h11);
    cyc(32'h0, 0, 0, 0, 0);
    idle();
    cyc(32'hCAFE_F00D, 0, 0, 0, 0);

    // Reset during an autopush stall
    shift(1, 5'd8, 32'h11);
    cyc(32'hCAFE_F00D, 0, 0, 0, 0);
    shift(1, 5'd8, 32'h22); bus.fifo_full = 1;
    cyc(32'h11CA_FEF0, 8, 1, 0, 0);
    rst = 1;
    cyc(32'h11CA_FEF0, 8, 0, 0, 0);         // stall masked while rst is high
    rst = 0; idle();
    cyc(32'h0, 0, 0, 0, 0);

    // n=32 and T=32 (both encoded as 0) push immediately
    bus.push_thresh = 5'd0;
    shift(0, 5'd0, 32'h55AA_55AA);
    cyc(32'h0, 0, 0, 1, 32'h55AA_55AA);
    idle();
    cyc(32'h0, 0, 0, 0, 0);

    // Drain the monitor, with a bounded wait
    for (int i = 0; i < 20 && (cyc_q.size() > 0 || push_q.size() > 0); i++) @(posedge clk);
    @(negedge clk); #1;
    chk("cyc_q_drained",  cyc_q.size(),  32'h0);
    chk("push_q_drained", push_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/input_shift_register.md
# input_shift_register

Per-state-machine input shift register (ISR) for the PIO core; the receive-side counterpart of `output_shift_register`. Shifts 1–32 bits per cycle from the synchronized GPIO input bus into a 32-bit register and counts shifted bits. Transfers completed words into the RX `fifo` by autopush on a threshold or by an explicit PUSH. Sits between `gpio.in_data` and the RX FIFO `data_in`/`push_en`, and is driven by the FSM instruction decode.

## Interface
Parameters: none (fixed 32-bit datapath, 5-bit counts).
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  32  pin values (already synchronized); bit 0 = lowest mapped pin
- `shift_en`  in  1  IN instruction: shift `shift_count` bits from `in_data`
- `shift_count`  in  5  bits per shift; 0 means 32
- `shiftdir`  in  1  1 = shift right (data enters at MSB), 0 = shift left (data enters at LSB)
- `autopush`  in  1  enable threshold autopush
- `push_thresh`  in  5  autopush threshold in bits; 0 means 32
- `push_req`  in  1  explicit PUSH instruction
- `push_block`  in  1  PUSH stalls when FIFO full (1) or drops the data (0)
- `mov_en`  in  1  MOV into ISR
- `mov_in`  in  32  MOV source data
- `fifo_full`  in  1  RX FIFO full status
- `mov_out`  out  32  current ISR contents (MOV source); equals `isr`
- `data_out`  out  32  word presented to RX FIFO; 0 when `fifo_push` = 0
- `fifo_push`  out  1  push strobe to RX FIFO `push_en`
- `stall`  out  1  instruction cannot complete this cycle; FSM holds PC and re-presents the instruction
- `input_shift_counter`  out  6  bits shifted since the last clear, saturating at 32

## Operation
- State: `isr[31:0]`, `input_shift_counter[5:0]`. Reset: both 0. `fifo_push`, `stall`, and `data_out` read 0 while `rst` is high.
- n = (`shift_count` == 0) ? 32 : `shift_count`; T = (`push_thresh` == 0) ? 32 : `push_thresh`.
- Shift right: `isr_next` = (`isr` >> n) | (`in_data`[n-1:0] << (32-n)). Shift left: `isr_next` = (`isr` << n) | `in_data`[n-1:0]. When n = 32, `isr_next` = `in_data`.
- `count_next` = min(`input_shift_counter` + n, 32) (7-bit add, then saturate).
- Priority when more than one request is high: `mov_en` > `push_req` > `shift_en`. A lower-priority request that loses is ignored. It is not queued.
- `mov_en`: `isr` <= `mov_in`, counter <= 0. Never stalls. Never pushes.
- `push_req`:
  - FIFO not full: `fifo_push` = 1, `data_out` = `isr`. Edge: `isr` <= 0, counter <= 0.
  - FIFO full and `push_block` = 1: `stall` = 1, no state change.
  - FIFO full and `push_block` = 0: no push. `isr` and counter are cleared (data dropped). No stall.
- `shift_en` with `autopush` = 0, or with `count_next` < T: `isr` <= `isr_next`, counter <= `count_next`. Never stalls. The counter saturates at 32, and further shifts keep shifting.
- `shift_en` with `autopush` = 1 and `count_next` >= T:
  - FIFO not full: `fifo_push` = 1, `data_out` = `isr_next`. Edge: `isr` <= 0, counter <= 0.
  - FIFO full: `stall` = 1. `isr` and counter are unchanged, and the shift is not applied. The shift retries each cycle while `shift_en` is held.
- Idle (no request): state holds. `fifo_push` = 0, `stall` = 0.

## Timing
- `fifo_push`, `data_out`, and `stall` are combinational from the current inputs and state, with no registered latency. The RX FIFO captures `data_out` on the same rising edge that updates the ISR.
- Shift, MOV, and push results are visible on `isr`/`mov_out`/`input_shift_counter` one cycle after the request.
- At most one FIFO push per cycle. `fifo_push` is never asserted while `fifo_full` = 1.
- Reset mid-stall: the next edge clears all state. `stall` drops in the same cycle `rst` is high.
- A full FIFO that frees on cycle k lets the stalled push or autopush complete on cycle k's edge.

## Test plan
- Reset, then left shift with n=8, `in_data`=0x000000A5; a second identical shift follows -> `isr`=0x000000A5, counter=8, then `isr`=0x0000A5A5, counter=16, `fifo_push`=0 throughout.
- Right shift with n=8 from 0, `in_data`=0x000000A5 -> `isr`=0xA5000000, counter=8. With `shift_count`=0 and `in_data`=0xDEADBEEF -> `isr`=0xDEADBEEF, counter saturates at 32.
- `autopush`=1, T=16, right, n=8, `in_data` 0x11 then 0x22, FIFO not full -> second cycle shows `fifo_push`=1 and `data_out`=0x22110000; afterwards `isr`=0 and counter=0.
- Same as the previous case but `fifo_full`=1 on the second shift for 3 cycles, then 0 -> `stall`=1 for 3 cycles with `isr`=0x11000000 held, then the push of 0x22110000 completes and `stall`=0.
- `isr`=0x12345678 with `push_req`, `fifo_full`=1: `push_block`=1 -> `stall`=1 and `isr` unchanged. `push_block`=0 -> no push, `isr`=0, counter=0.
- `mov_en`, `push_req`, and `shift_en` all high with `mov_in`=0xCAFEF00D -> `isr`=0xCAFEF00D, counter=0, `fifo_push`=0. Asserting `rst` during an autopush stall -> next cycle all outputs are 0.
